// File: rtl/apb_init_pkg.sv
// Shared types and default widths for the command-driven APB initiator.
package apb_init_pkg;

    localparam int unsigned APB_ADDR_W     = 32;
    localparam int unsigned APB_DATA_W     = 32;
    localparam int unsigned APB_FIFO_DEPTH = 4;
    localparam int unsigned APB_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_initiator_if.sv
// APB bus bundle between the initiator (master) and a responder (slave).
interface apb_cmd_initiator_if
    import apb_init_pkg::*;
#(
    parameter int unsigned ADDR_W = APB_ADDR_W,
    parameter int unsigned DATA_W = APB_DATA_W
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_init_fifo.sv
// In-order command FIFO; registered status flags, no push-through when full.
module apb_init_fifo
    import apb_init_pkg::*;
#(
    parameter int unsigned DEPTH = APB_FIFO_DEPTH
) (
    input  logic     PCLK,
    input  logic     PRESET,
    input  logic     push,
    input  apb_cmd_t wr_cmd,
    input  logic     pop,
    output apb_cmd_t rd_cmd,
    output logic     not_full,
    output logic     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    apb_cmd_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_nxt;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        do_push   = push && not_full;
        do_pop    = pop && !empty;
        count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    assign rd_cmd = mem[rd_ptr];

    always_ff @(posedge PCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_cmd;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            not_full <= 1'b1;
            empty    <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_nxt;
            not_full <= (count_nxt != CNT_W'(DEPTH));
            empty    <= (count_nxt == CNT_W'(0));
        end
    end
endmodule

// File: rtl/apb_cmd_initiator.sv
// Queued valid/ready commands to APB SETUP/ACCESS transfers with per-transfer responses.
// Optional hung-transfer abort enabled by defining APB_INIT_TIMEOUT_EN.
module apb_cmd_initiator
    import apb_init_pkg::*;
#(
    parameter int unsigned ADDR_W     = APB_ADDR_W,
    parameter int unsigned DATA_W     = APB_DATA_W,
    parameter int unsigned FIFO_DEPTH = APB_FIFO_DEPTH,
    parameter int unsigned TIMEOUT    = APB_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    apb_cmd_initiator_if.master apb
);
    apb_state_e state;
    logic       loaded;
    apb_cmd_t   push_cmd;
    apb_cmd_t   head;
    logic       fifo_not_full;
    logic       fifo_empty;
    logic       pop;
    logic       timeout_hit;

    always_comb begin
        push_cmd = '{write: cmd_write,
                     addr:  APB_ADDR_W'(cmd_addr),
                     wdata: APB_DATA_W'(cmd_wdata)};
    end

    // Pop either from IDLE (staging the next command) or on a completing ACCESS.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == ST_IDLE && !loaded)                pop = 1'b1;
            else if (state == ST_ACCESS && apb.PREADY)      pop = 1'b1;
        end
    end

    apb_init_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .push     (cmd_valid),
        .wr_cmd   (push_cmd),
        .pop      (pop),
        .rd_cmd   (head),
        .not_full (fifo_not_full),
        .empty    (fifo_empty)
    );

    assign cmd_ready = fifo_not_full;

`ifdef APB_INIT_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt;

    assign timeout_hit = (state == ST_ACCESS) && !apb.PREADY &&
                         (tcnt == TCNT_W'(TIMEOUT - 1));

    // Counts low-PREADY ACCESS cycles; clears on completion, abort or leaving ACCESS.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tcnt <= '0;
        end else if (state == ST_ACCESS && !apb.PREADY && !timeout_hit) begin
            tcnt <= tcnt + TCNT_W'(1);
        end else begin
            tcnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= ST_IDLE;
            loaded      <= 1'b0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (loaded) begin
                        loaded   <= 1'b0;
                        apb.PSEL <= 1'b1;
                        state    <= ST_SETUP;
                    end else if (!fifo_empty) begin
                        loaded     <= 1'b1;
                        apb.PWRITE <= head.write;
                        apb.PADDR  <= ADDR_W'(head.addr);
                        apb.PWDATA <= DATA_W'(head.wdata);
                    end
                end
                ST_SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (apb.PREADY) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
                        apb.PENABLE <= 1'b0;
                        if (!fifo_empty) begin
                            apb.PWRITE <= head.write;
                            apb.PADDR  <= ADDR_W'(head.addr);
                            apb.PWDATA <= DATA_W'(head.wdata);
                            state      <= ST_SETUP;
                        end else begin
                            apb.PSEL <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end else if (timeout_hit) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_cmd_initiator.sv
// Bench for apb_cmd_initiator: perimeter-style responder, response scoreboard, bus monitors.
module tb_apb_cmd_initiator;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    apb_cmd_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_cmd_initiator #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (bus)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: regs at 0x0/0x4, perimeter 2*(a+b) at 0x8, wait states or stuck PREADY.
    int          wait_target = 0;
    bit          stuck = 1'b0;
    int          wcnt = 0;
    logic [31:0] reg_a = 32'h0;
    logic [31:0] reg_b = 32'h0;

    assign bus.PREADY = !stuck && (wcnt >= wait_target);

    always_comb begin
        case (bus.PADDR)
            32'h0:   bus.PRDATA = reg_a;
            32'h4:   bus.PRDATA = reg_b;
            32'h8:   bus.PRDATA = (reg_a + reg_b) << 1;
            default: bus.PRDATA = {16'hDEAD, bus.PADDR[15:0]};
        endcase
        if (bus.PWRITE) bus.PRDATA = 32'hBADBAD00;
    end

    always @(posedge PCLK) begin
        if (PRESET || !(bus.PSEL && bus.PENABLE)) begin
            wcnt <= 0;
        end else if (bus.PREADY) begin
            wcnt <= 0;
            if (bus.PWRITE && bus.PADDR == 32'h0) reg_a <= bus.PWDATA;
            if (bus.PWRITE && bus.PADDR == 32'h4) reg_b <= bus.PWDATA;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    // Address/data/direction must hold from SETUP through every ACCESS cycle.
    logic [31:0] hold_addr, hold_wdata;
    logic        hold_write;
    always @(negedge PCLK) begin
        if (bus.PSEL && !bus.PENABLE) begin
            hold_addr  = bus.PADDR;
            hold_wdata = bus.PWDATA;
            hold_write = bus.PWRITE;
        end else if (bus.PSEL && bus.PENABLE) begin
            check_eq("paddr_stable",  bus.PADDR, hold_addr);
            check_eq("pwdata_stable", bus.PWDATA, hold_wdata);
            check_eq("pwrite_stable", 32'(bus.PWRITE), 32'(hold_write));
        end
    end

    typedef struct {
        logic [31:0] rdata;
        bit          err;
    } exp_t;
    exp_t sb[$];

    // rsp_valid must pulse exactly in the cycle after a completion or abort edge.
    bit   pend = 1'b0;
    int   mcnt = 0;
    int   rsp_count = 0;
    exp_t got;
    always @(negedge PCLK) begin
        check_eq("rsp_valid_timing", 32'(rsp_valid), 32'(pend));
        if (rsp_valid) begin
            rsp_count++;
            check_eq("rsp_has_expected", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check_eq("rsp_rdata", rsp_rdata, got.rdata);
                check_eq("rsp_err", 32'(rsp_err), 32'(got.err));
            end
        end
        pend = 1'b0;
        if (!PRESET && bus.PSEL && bus.PENABLE) begin
            if (bus.PREADY) begin
                pend = 1'b1;
                mcnt = 0;
            end
`ifdef APB_INIT_TIMEOUT_EN
            else if (mcnt == TMO - 1) begin
                pend = 1'b1;
                mcnt = 0;
            end
`endif
            else begin
                mcnt++;
            end
        end else begin
            mcnt = 0;
        end
    end

    task automatic push(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input bit ee);
        int c = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge PCLK);
        while (!cmd_ready && c < 50) begin
            @(negedge PCLK);
            c++;
        end
        check_eq("cmd_accept", 32'(cmd_ready), 32'h1);
        if (cmd_ready) begin
            @(posedge PCLK);
            sb.push_back('{rdata: er, err: ee});
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while (sb.size() != 0 && c < 300) begin
            @(negedge PCLK);
            c++;
        end
        check_eq(name, 32'(sb.size()), 32'h0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_psel"},      32'(bus.PSEL), 32'h0);
        check_eq({tag, "_penable"},   32'(bus.PENABLE), 32'h0);
        check_eq({tag, "_pwrite"},    32'(bus.PWRITE), 32'h0);
        check_eq({tag, "_paddr"},     bus.PADDR, 32'h0);
        check_eq({tag, "_pwdata"},    bus.PWDATA, 32'h0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check_eq({tag, "_rsp_err"},   32'(rsp_err), 32'h0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
    endtask

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;
    vec_t vecs[10];

    initial begin
        int c;
        int saved;
        vecs[0] = '{1'b1, 32'h0, 32'd5,    0, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 32'h4, 32'd7,    1, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 32'h8, 32'h0,    0, 32'd24,       1'b0};
        vecs[3] = '{1'b0, 32'h0, 32'h0,    2, 32'd5,        1'b0};
        vecs[4] = '{1'b1, 32'h0, 32'd3,    0, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 32'h8, 32'h0,    3, 32'd20,       1'b0};
        vecs[6] = '{1'b0, 32'h4, 32'h0,    0, 32'd7,        1'b0};
        vecs[7] = '{1'b1, 32'h0, 32'h12,   3, 32'h0,        1'b0};
        vecs[8] = '{1'b0, 32'h0, 32'h0,    1, 32'h12,       1'b0};
        vecs[9] = '{1'b0, 32'hC, 32'h0,    0, 32'hDEAD000C, 1'b0};

        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        check_reset_vals("reset");

        // First-transfer latency from an idle, empty initiator.
        @(posedge PCLK); #1;
        push(1'b1, 32'hC, 32'h1, 32'h0, 1'b0);
        @(negedge PCLK); check_eq("lat_k0_psel", 32'(bus.PSEL), 32'h0);
        @(negedge PCLK); check_eq("lat_k1_psel", 32'(bus.PSEL), 32'h0);
        @(negedge PCLK); check_eq("lat_k2_psel", 32'(bus.PSEL), 32'h1);
                         check_eq("lat_k2_penable", 32'(bus.PENABLE), 32'h0);
        @(negedge PCLK); check_eq("lat_k3_penable", 32'(bus.PENABLE), 32'h1);
        @(negedge PCLK); check_eq("lat_k4_rsp_valid", 32'(rsp_valid), 32'h1);
        @(negedge PCLK); check_eq("lat_k5_rsp_valid", 32'(rsp_valid), 32'h0);
        drain("drain_latency");

        for (int i = 0; i < 10; i++) begin
            @(posedge PCLK); #1;
            wait_target = vecs[i].waits;
            push(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
            drain("drain_vec");
        end

        // Fill the FIFO while the bus is stalled, then let it drain in order.
        @(posedge PCLK); #1;
        wait_target = 0;
        stuck = 1'b1;
        push(1'b0, 32'h0,  32'h0,  32'h12,       1'b0);
        push(1'b1, 32'h4,  32'h20, 32'h0,        1'b0);
        push(1'b0, 32'h8,  32'h0,  32'h64,       1'b0);
        push(1'b0, 32'h14, 32'h0,  32'hDEAD0014, 1'b0);
        push(1'b1, 32'h18, 32'h1,  32'h0,        1'b0);
        @(negedge PCLK);
        check_eq("full_cmd_ready", 32'(cmd_ready), 32'h0);
        @(posedge PCLK); #1;
        stuck = 1'b0;
        drain("drain_full");

        // Reset in the middle of an ACCESS with commands queued.
        @(posedge PCLK); #1;
        stuck = 1'b1;
        push(1'b1, 32'h0, 32'h55, 32'h0, 1'b0);
        push(1'b0, 32'h4, 32'h0,  32'h0, 1'b0);
        push(1'b0, 32'h8, 32'h0,  32'h0, 1'b0);
        c = 0;
        while (!(bus.PSEL && bus.PENABLE) && c < 20) begin
            @(negedge PCLK);
            c++;
        end
        check_eq("reach_access", 32'(bus.PSEL && bus.PENABLE), 32'h1);
        saved = rsp_count;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        sb.delete();
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        stuck  = 1'b0;
        @(negedge PCLK);
        check_reset_vals("midreset");
        repeat (12) @(negedge PCLK);
        check_eq("midreset_no_rsp", 32'(rsp_count - saved), 32'h0);

        // Zero-wait stream: PSEL held, PENABLE alternating, one transfer per 2 cycles.
        @(posedge PCLK); #1;
        push(1'b0, 32'h0, 32'h0, 32'h12, 1'b0);
        push(1'b0, 32'h4, 32'h0, 32'h20, 1'b0);
        push(1'b0, 32'h8, 32'h0, 32'h64, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            check_eq("stream_psel", 32'(bus.PSEL), 32'h1);
            check_eq("stream_penable", 32'(bus.PENABLE), 32'(i % 2));
        end
        @(negedge PCLK);
        check_eq("stream_end_psel", 32'(bus.PSEL), 32'h0);
        drain("drain_stream");

`ifdef APB_INIT_TIMEOUT_EN
        // Hung read is aborted; the queued write then completes normally.
        @(posedge PCLK); #1;
        stuck = 1'b1;
        push(1'b0, 32'h8, 32'h0, 32'h0, 1'b1);
        push(1'b1, 32'h0, 32'h9, 32'h0, 1'b0);
        c = 0;
        while (sb.size() > 1 && c < 100) begin
            @(negedge PCLK);
            c++;
        end
        check_eq("timeout_abort_seen", 32'(sb.size()), 32'h1);
        @(posedge PCLK); #1;
        stuck = 1'b0;
        drain("drain_timeout");
        @(posedge PCLK); #1;
        push(1'b0, 32'h0, 32'h0, 32'h9, 1'b0);
        drain("drain_after_timeout");
`endif

        repeat (4) @(negedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1);
    end
endmodule
